vga_tx_timing: RTL

VGA_TX_TIMING -- requirements
Module: vga_tx_timing

---
 rtl/vga_tx_timing.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_tx_timing.sv
// vga_tx_timing: 640x480@60 VGA raster generator (parameterisable).
// Walks the screen with free-running column/line counters. Each counter
// is shadowed by a phase FSM (ACTIVE/FRONT/SYNC/BACK). The FSM publishes
// the pixel request coordinates combinationally. It registers the returned
// pixel together with the syncs and blank, so the output lags the request
// by exactly one clock.
`timescale 1ns/1ps

module vga_tx_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        display_on,
  input  logic [23:0] RGB,
  output logic [9:0]  ColunaOut,
  output logic [9:0]  LinhaOut,
  output logic        h_sync,
  output logic        v_sync,
  output logic        blank,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last count value of each phase; a phase ends when its counter sits here.
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  logic       r_run;       // low only until the first edge after reset
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic [1:0] r_h_state;
  logic [1:0] r_v_state;

  logic       r_h_sync;
  logic       r_v_sync;
  logic       r_blank;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;
  logic       r_frame_start;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_visible;
  logic [1:0] w_h_state_next;
  logic [1:0] w_v_state_next;

  assign w_h_wrap  = (r_hcnt == H_LAST);
  assign w_v_wrap  = (r_vcnt == V_LAST);
  assign w_visible = (r_h_state == ST_ACTIVE) && (r_v_state == ST_ACTIVE);

  // Horizontal phase FSM: advance when the column reaches the end of a phase.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    w_h_state_next = r_h_state;
    case (r_h_state)
      ST_ACTIVE: if (r_hcnt == H_ACT_END)  w_h_state_next = ST_FRONT;
      ST_FRONT:  if (r_hcnt == H_FP_END)   w_h_state_next = ST_SYNC;
      ST_SYNC:   if (r_hcnt == H_SYNC_END) w_h_state_next = ST_BACK;
      default:   if (w_h_wrap)             w_h_state_next = ST_ACTIVE;
    endcase
  end

  // Vertical phase FSM: same phase order, evaluated on the line counter.
  always_comb begin
    w_v_state_next = r_v_state;
    case (r_v_state)
      ST_ACTIVE: if (r_vcnt == V_ACT_END)  w_v_state_next = ST_FRONT;
      ST_FRONT:  if (r_vcnt == V_FP_END)   w_v_state_next = ST_SYNC;
      ST_SYNC:   if (r_vcnt == V_SYNC_END) w_v_state_next = ST_BACK;
      default:   if (w_v_wrap)             w_v_state_next = ST_ACTIVE;
    endcase
  end

  // Raster counters and phase states; the first edge after reset only arms
  // the raster so that pixel (0,0) is requested for a full clock.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
      r_run     <= 1'b0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_h_state <= ST_ACTIVE;
      r_v_state <= ST_ACTIVE;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      r_hcnt    <= w_h_wrap ? '0 : r_hcnt + 10'd1;
      r_h_state <= w_h_state_next;
      if (w_h_wrap) begin
        r_vcnt    <= w_v_wrap ? '0 : r_vcnt + 10'd1;
        r_v_state <= w_v_state_next;
      end
    end
  end

  // Output stage: pixel, syncs, blank and frame marker registered together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_h_sync      <= 1'b1;
      r_v_sync      <= 1'b1;
      r_blank       <= 1'b0;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
      r_frame_start <= 1'b0;
    end else if (r_run) begin
      r_h_sync      <= (r_h_state != ST_SYNC);
      r_v_sync      <= (r_v_state != ST_SYNC);
      r_blank       <= w_visible;
      r_r           <= (w_visible && display_on) ? RGB[23:16] : 8'h00;
      r_g           <= (w_visible && display_on) ? RGB[15:8]  : 8'h00;
      r_b           <= (w_visible && display_on) ? RGB[7:0]   : 8'h00;
      r_frame_start <= (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    end
  end

  // Request coordinates are only meaningful inside the visible area.
  assign ColunaOut   = w_visible ? r_hcnt : 10'd0;
  assign LinhaOut    = w_visible ? r_vcnt : 10'd0;

  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign blank       = r_blank;
  assign R           = r_r;
  assign G           = r_g;
  assign B           = r_b;
  assign frame_start = r_frame_start;

endmodule
